// File: rtl/alu_mul_sequencer_pkg.sv
// alu_mul_sequencer_pkg: ALU opcodes, widths and sequencer state encoding
package alu_mul_sequencer_pkg;
  localparam int DATA_W = 16;
  localparam int OP_W = 4;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SLL = 4'b0101;
  localparam logic [OP_W-1:0] OP_SRL = 4'b0110;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    STEP = 3'd1,
    ADD  = 3'd2,
    SHL  = 3'd3,
    SHR  = 3'd4,
    DONE = 3'd5
  } state_t;
endpackage

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-add multiplier driving the shared ALU for the low 16 bits of A*B
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
(
  input  logic              CLK,
  input  logic              Reset,
  input  logic              input_Start,
  input  logic [DATA_W-1:0] input_A,
  input  logic [DATA_W-1:0] input_B,
  input  logic [DATA_W-1:0] input_ALUResult,
  output logic              output_ALUGrant,
  output logic [DATA_W-1:0] output_ALU_A,
  output logic [DATA_W-1:0] output_ALU_B,
  output logic [OP_W-1:0]   output_ALUOp,
  output logic              output_Busy,
  output logic              output_Done,
  output logic [DATA_W-1:0] output_Product
);
  state_t state, next_state;
  logic [DATA_W-1:0] acc, mcand, mplier;
  logic accept, finish;
  always_comb begin
    accept = state == IDLE && input_Start;
    finish = state == STEP && mplier == '0;
    next_state = state == IDLE ? (input_Start ? STEP : IDLE)
               : state == STEP ? (mplier == '0 ? DONE : mplier[0] ? ADD : SHL)
               : state == ADD  ? SHL
               : state == SHL  ? SHR
               : state == SHR  ? STEP
               : IDLE;
    output_Busy = state == STEP || state == ADD || state == SHL || state == SHR;
    output_ALUGrant = output_Busy;
    output_Done = state == DONE;
    output_ALU_A = state == ADD ? acc : state == SHL ? mcand : state == SHR ? mplier : '0;
    output_ALU_B = state == ADD ? mcand : (state == SHL || state == SHR) ? DATA_W'(1) : '0;
    output_ALUOp = state == SHL ? OP_SLL : state == SHR ? OP_SRL : OP_ADD;
  end
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      output_Product <= '0;
    end else begin
      state <= next_state;
      acc <= accept ? '0 : state == ADD ? input_ALUResult : acc;
      mcand <= accept ? input_A : state == SHL ? input_ALUResult : mcand;
      mplier <= accept ? input_B : state == SHR ? input_ALUResult : mplier;
      output_Product <= finish ? acc : output_Product;
    end
  end
endmodule
